// File: rtl/pcie_os_detect.sv
// Multi-lane receive ordered-set detector for the 8b/10b PCIe physical layer.
// Each lane tracks COM-led K-symbol runs and reports SKP/EIOS/FTS completion and malformed sets.

module pcie_os_detect #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned FTS_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sym_valid,
    input  logic [8*LANES-1:0]     sym_data,
    input  logic [LANES-1:0]       sym_k,
    input  logic                   fts_clr,
    output logic [LANES-1:0]       skp_det,
    output logic [LANES-1:0]       eios_det,
    output logic [LANES-1:0]       fts_det,
    output logic [LANES-1:0]       os_err,
    output logic                   all_eios,
    output logic [FTS_CNT_W-1:0]   fts_count
);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_IDL = 8'h7C;

    typedef enum logic [2:0] {
        StIdle,
        StComSeen,
        StSkpRun,
        StIdlRun,
        StFtsRun
    } state_e;

    state_e                 state_q [LANES];
    state_e                 state_d [LANES];
    logic [2:0]             cnt_q   [LANES];
    logic [2:0]             cnt_d   [LANES];
    logic [7:0]             lane_sym [LANES];

    logic [LANES-1:0]       skp_det_d, skp_det_q;
    logic [LANES-1:0]       eios_det_d, eios_det_q;
    logic [LANES-1:0]       fts_det_d, fts_det_q;
    logic [LANES-1:0]       os_err_d, os_err_q;
    logic [LANES-1:0]       eios_seen_d, eios_seen_q;
    logic [LANES-1:0]       eios_union;
    logic                   all_eios_d, all_eios_q;
    logic [FTS_CNT_W-1:0]   fts_count_d, fts_count_q;

    // A symbol that ends or breaks a run is treated as if it arrived in IDLE.
    function automatic state_e from_idle(input logic k, input logic [7:0] s);
        return (k && s == K_COM) ? StComSeen : StIdle;
    endfunction

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_sym[i] = sym_data[8*i +: 8];
        end
    end

    always_comb begin
        skp_det_d  = '0;
        eios_det_d = '0;
        fts_det_d  = '0;
        os_err_d   = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (sym_valid) begin
                case (state_q[i])
                    StIdle: begin
                        state_d[i] = from_idle(sym_k[i], lane_sym[i]);
                    end
                    StComSeen: begin
                        if (!sym_k[i]) begin
                            state_d[i] = StIdle;
                        end else if (lane_sym[i] == K_COM) begin
                            state_d[i] = StComSeen;
                        end else if (lane_sym[i] == K_SKP) begin
                            state_d[i] = StSkpRun;
                            cnt_d[i]   = 3'd1;
                        end else if (lane_sym[i] == K_IDL) begin
                            state_d[i] = StIdlRun;
                            cnt_d[i]   = 3'd1;
                        end else if (lane_sym[i] == K_FTS) begin
                            state_d[i] = StFtsRun;
                            cnt_d[i]   = 3'd1;
                        end else begin
                            os_err_d[i] = 1'b1;
                            state_d[i]  = StIdle;
                        end
                    end
                    StSkpRun: begin
                        if (sym_k[i] && lane_sym[i] == K_SKP) begin
                            if (cnt_q[i] == 3'd5) begin
                                os_err_d[i] = 1'b1;
                                state_d[i]  = StIdle;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 3'd1;
                            end
                        end else begin
                            skp_det_d[i] = 1'b1;
                            state_d[i]   = from_idle(sym_k[i], lane_sym[i]);
                        end
                    end
                    StIdlRun: begin
                        if (sym_k[i] && lane_sym[i] == K_IDL) begin
                            if (cnt_q[i] == 3'd2) begin
                                eios_det_d[i] = 1'b1;
                                state_d[i]    = StIdle;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 3'd1;
                            end
                        end else begin
                            os_err_d[i] = 1'b1;
                            state_d[i]  = from_idle(sym_k[i], lane_sym[i]);
                        end
                    end
                    StFtsRun: begin
                        if (sym_k[i] && lane_sym[i] == K_FTS) begin
                            if (cnt_q[i] == 3'd2) begin
                                fts_det_d[i] = 1'b1;
                                state_d[i]   = StIdle;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 3'd1;
                            end
                        end else begin
                            os_err_d[i] = 1'b1;
                            state_d[i]  = from_idle(sym_k[i], lane_sym[i]);
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                    end
                endcase
            end
        end
    end

    // Lanes completing on this edge count toward the link-wide EIOS event immediately.
    always_comb begin
        eios_union  = eios_seen_q | eios_det_d;
        all_eios_d  = &eios_union;
        eios_seen_d = all_eios_d ? '0 : eios_union;
    end

    always_comb begin
        fts_count_d = fts_count_q;
        if (fts_clr) begin
            fts_count_d = '0;
        end else if (fts_det_d[0] && !(&fts_count_q)) begin
            fts_count_d = fts_count_q + {{(FTS_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            skp_det_q   <= '0;
            eios_det_q  <= '0;
            fts_det_q   <= '0;
            os_err_q    <= '0;
            eios_seen_q <= '0;
            all_eios_q  <= 1'b0;
            fts_count_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            skp_det_q   <= skp_det_d;
            eios_det_q  <= eios_det_d;
            fts_det_q   <= fts_det_d;
            os_err_q    <= os_err_d;
            eios_seen_q <= eios_seen_d;
            all_eios_q  <= all_eios_d;
            fts_count_q <= fts_count_d;
        end
    end

    assign skp_det   = skp_det_q;
    assign eios_det  = eios_det_q;
    assign fts_det   = fts_det_q;
    assign os_err    = os_err_q;
    assign all_eios  = all_eios_q;
    assign fts_count = fts_count_q;

endmodule

// File: tb/tb_pcie_os_detect.sv
// Directed self-checking bench for pcie_os_detect (4 lanes, 8-bit FTS counter).
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.

module tb_pcie_os_detect;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] FTS = 8'h3C;
    localparam logic [7:0] IDL = 8'h7C;

    logic        clk;
    logic        rst_n;
    logic        sym_valid;
    logic [31:0] sym_data;
    logic [3:0]  sym_k;
    logic        fts_clr;
    logic [3:0]  skp_det;
    logic [3:0]  eios_det;
    logic [3:0]  fts_det;
    logic [3:0]  os_err;
    logic        all_eios;
    logic [7:0]  fts_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    pcie_os_detect #(
        .LANES     (4),
        .FTS_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_k     (sym_k),
        .fts_clr   (fts_clr),
        .skp_det   (skp_det),
        .eios_det  (eios_det),
        .fts_det   (fts_det),
        .os_err    (os_err),
        .all_eios  (all_eios),
        .fts_count (fts_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one symbol slot, then wait until its registered result is visible.
    task automatic step(input logic [31:0] d, input logic [3:0] k, input logic v);
        @(negedge clk);
        sym_data  = d;
        sym_k     = k;
        sym_valid = v;
        @(posedge clk);
        #1;
    endtask

    // One symbol on a single lane; every other lane carries data byte 0x00.
    task automatic one(input int l, input logic [7:0] b, input logic k);
        logic [31:0] w;
        logic [3:0]  km;
        w           = '0;
        w[8*l +: 8] = b;
        km          = '0;
        km[l]       = k;
        step(w, km, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  km;
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym_data  = '0;
        sym_k     = '0;
        fts_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_skp", {28'd0, skp_det}, 32'h0);
        chk("rst_eios", {28'd0, eios_det}, 32'h0);
        chk("rst_fts", {28'd0, fts_det}, 32'h0);
        chk("rst_err", {28'd0, os_err}, 32'h0);
        chk("rst_all", {31'd0, all_eios}, 32'h0);
        chk("rst_cnt", {24'd0, fts_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SKP OS on lane 0 terminated by a data byte
        one(0, COM, 1'b1); chk("skp_com", {28'd0, skp_det}, 32'h0);
        one(0, SKP, 1'b1); chk("skp_s1", {28'd0, skp_det}, 32'h0);
        one(0, SKP, 1'b1); chk("skp_s2", {28'd0, skp_det}, 32'h0);
        one(0, SKP, 1'b1); chk("skp_s3", {28'd0, skp_det}, 32'h0);
        one(0, 8'h4A, 1'b0);
        chk("skp_det", {28'd0, skp_det}, 32'h1);
        chk("skp_noerr", {28'd0, os_err}, 32'h0);
        one(0, 8'h00, 1'b0);
        chk("skp_one_cyc", {28'd0, skp_det}, 32'h0);

        // Six SKPs on lane 1 is malformed
        one(1, COM, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            one(1, SKP, 1'b1);
            chk("skp6_err", {28'd0, os_err}, (i == 6) ? 32'h2 : 32'h0);
            chk("skp6_noskp", {28'd0, skp_det}, 32'h0);
        end
        one(1, 8'h00, 1'b0);
        chk("skp6_after", {28'd0, skp_det | os_err}, 32'h0);

        // COM in the terminating slot starts the next SKP OS with no bubble
        one(0, COM, 1'b1); one(0, SKP, 1'b1);
        one(0, COM, 1'b1); chk("b2b_skp1", {28'd0, skp_det}, 32'h1);
        one(0, SKP, 1'b1); chk("b2b_mid", {28'd0, skp_det}, 32'h0);
        one(0, 8'h11, 1'b0); chk("b2b_skp2", {28'd0, skp_det}, 32'h1);

        // Staggered EIOS: lane i starts one slot after lane i-1
        for (int j = 0; j < 7; j++) begin
            w  = '0;
            km = '0;
            for (int l = 0; l < 4; l++) begin
                if (j - l == 0) begin
                    w[8*l +: 8] = COM;
                    km[l]       = 1'b1;
                end else if (j - l >= 1 && j - l <= 3) begin
                    w[8*l +: 8] = IDL;
                    km[l]       = 1'b1;
                end
            end
            step(w, km, 1'b1);
            chk("stag_eios", {28'd0, eios_det}, (j >= 3) ? (32'h1 << (j - 3)) : 32'h0);
            chk("stag_all", {31'd0, all_eios}, (j == 6) ? 32'h1 : 32'h0);
        end
        step(32'h0, 4'h0, 1'b1);
        chk("stag_all_off", {31'd0, all_eios}, 32'h0);

        // All lanes complete EIOS on the same edge
        step({4{COM}}, 4'hF, 1'b1);
        step({4{IDL}}, 4'hF, 1'b1);
        step({4{IDL}}, 4'hF, 1'b1);
        step({4{IDL}}, 4'hF, 1'b1);
        chk("sim_eios", {28'd0, eios_det}, 32'hF);
        chk("sim_all", {31'd0, all_eios}, 32'h1);

        // 257 FTS OS on lane 0: counter saturates at 255
        for (int n = 1; n <= 257; n++) begin
            one(0, COM, 1'b1);
            one(0, FTS, 1'b1);
            one(0, FTS, 1'b1);
            one(0, FTS, 1'b1);
            if (n == 1) chk("fts_det0", {28'd0, fts_det}, 32'h1);
            if (n == 1 || n == 254 || n == 255 || n == 256 || n == 257)
                chk("fts_cnt", {24'd0, fts_count}, (n > 255) ? 32'd255 : n);
        end
        one(0, COM, 1'b1);
        one(0, FTS, 1'b1);
        one(0, FTS, 1'b1);
        fts_clr = 1'b1;
        one(0, FTS, 1'b1);
        fts_clr = 1'b0;
        chk("clr_det", {28'd0, fts_det}, 32'h1);
        chk("clr_cnt", {24'd0, fts_count}, 32'h0);
        one(0, COM, 1'b1); one(0, FTS, 1'b1); one(0, FTS, 1'b1); one(0, FTS, 1'b1);
        chk("post_clr_cnt", {24'd0, fts_count}, 32'h1);

        // EIOS on lane 2 with a 3-cycle invalid gap before the last IDL
        one(2, COM, 1'b1);
        one(2, IDL, 1'b1);
        one(2, IDL, 1'b1);
        for (int g = 0; g < 3; g++) begin
            step({8'h00, COM, 16'h0000}, 4'b0100, 1'b0);
            chk("gap_quiet", {28'd0, eios_det | os_err}, 32'h0);
        end
        one(2, IDL, 1'b1);
        chk("gap_eios", {28'd0, eios_det}, 32'h4);
        chk("gap_all", {31'd0, all_eios}, 32'h0);

        // Reset in the middle of an SKP OS aborts it
        one(0, COM, 1'b1);
        one(0, SKP, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        one(0, 8'h4A, 1'b0);
        chk("rst_mid_skp", {28'd0, skp_det}, 32'h0);
        chk("rst_mid_err", {28'd0, os_err}, 32'h0);

        // Broken EIOS on lane 3
        one(3, COM, 1'b1);
        one(3, IDL, 1'b1);
        one(3, 8'h00, 1'b0);
        chk("bad_eios_err", {28'd0, os_err}, 32'h8);
        chk("bad_eios_det", {28'd0, eios_det}, 32'h0);
        one(3, 8'h00, 1'b0);
        chk("bad_eios_once", {28'd0, os_err}, 32'h0);

        // Repeated COM then FTS OS on lane 3
        one(3, COM, 1'b1); chk("com2_a", {28'd0, os_err}, 32'h0);
        one(3, COM, 1'b1); chk("com2_b", {28'd0, os_err}, 32'h0);
        one(3, FTS, 1'b1);
        one(3, FTS, 1'b1);
        one(3, FTS, 1'b1);
        chk("l3_fts", {28'd0, fts_det}, 32'h8);
        chk("l3_noerr", {28'd0, os_err}, 32'h0);
        chk("l3_cnt", {24'd0, fts_count}, 32'h0);
        one(3, 8'h00, 1'b0);
        chk("l3_fts_once", {28'd0, fts_det}, 32'h0);

        // Unknown K symbol after COM is malformed
        one(1, COM, 1'b1);
        one(1, 8'hF7, 1'b1);
        chk("bad_k", {28'd0, os_err}, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_os_detect.md
# pcie_os_detect

Receive-side multi-lane ordered-set detector for the PCIe Gen1/Gen2 8b/10b physical layer. It sits after per-lane 10b/8b decode and before the LTSSM. Each lane tracks COM-led K-symbol sequences and reports:
- completed SKP, EIOS and FTS ordered sets;
- malformed ordered sets;
- a link-wide all-lanes-EIOS event;
- a saturating count of FTS ordered sets on lane 0.

## Interface
Parameters:
- LANES, 4, number of lanes (1..16)
- FTS_CNT_W, 8, width of fts_count

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- sym_valid  in  1  all lanes carry a valid decoded symbol this cycle
- sym_data  in  8*LANES  decoded symbol; lane i is bits [8i+7:8i]
- sym_k  in  LANES  control-symbol flag per lane
- fts_clr  in  1  synchronous clear of fts_count
- skp_det  out  LANES  one-cycle pulse: SKP OS completed
- eios_det  out  LANES  one-cycle pulse: EIOS completed
- fts_det  out  LANES  one-cycle pulse: FTS OS completed
- os_err  out  LANES  one-cycle pulse: malformed OS
- all_eios  out  1  one-cycle pulse: every lane has reported EIOS
- fts_count  out  FTS_CNT_W  FTS OS count on lane 0, saturating

## Operation
K-symbol codes (sym_k=1):
- COM = 0xBC (K28.5)
- SKP = 0x1C (K28.0)
- FTS = 0x3C (K28.1)
- IDL = 0x7C (K28.3)

Each lane runs an independent FSM with states IDLE, COM_SEEN, SKP_RUN, IDL_RUN and FTS_RUN, plus a 3-bit run counter. The FSM advances only on cycles where sym_valid=1. When sym_valid=0, state and counters hold and no pulses are generated.

IDLE:
- K COM -> COM_SEEN.
- Any other symbol -> stay in IDLE.

COM_SEEN:
- K SKP, K IDL or K FTS -> SKP_RUN, IDL_RUN or FTS_RUN respectively, with cnt=1.
- K COM -> stay in COM_SEEN.
- Data symbol (start of TS1/TS2) -> IDLE, no error.
- Any other K symbol -> os_err, IDLE.

SKP_RUN:
- K SKP with cnt<5 -> cnt+1.
- K SKP with cnt=5 (six SKPs received) -> os_err, IDLE.
- Any other symbol -> skp_det. The terminating symbol is then re-evaluated as if the FSM were in IDLE, so a K COM goes to COM_SEEN.
- An SKP OS may therefore contain 1..5 SKP symbols.

IDL_RUN and FTS_RUN:
- Matching K symbol with cnt<2 -> cnt+1.
- Matching K symbol with cnt=2 -> eios_det or fts_det respectively, then IDLE.
- Any other symbol -> os_err, and that symbol is re-evaluated as from IDLE.

Link-level behaviour:
- eios_seen[LANES-1:0] sets the bit for lane i when lane i completes an EIOS.
- When the OR of the already-set bits and the newly completing lanes equals all ones, all_eios pulses and every eios_seen bit clears.
- fts_count increments, saturating at all ones, when lane 0 completes an FTS OS.
- fts_clr forces fts_count to 0 and wins over a simultaneous increment.

## Timing
- All outputs are registered.
- For a terminating or completing symbol sampled at clock edge t, the pulse is high during cycle t+1 for exactly one cycle. This applies to:
  - skp_det: the first non-SKP symbol;
  - eios_det and fts_det: the third IDL or FTS;
  - os_err: the offending symbol.
- all_eios is high in the same cycle as the eios_det pulse of the last lane to complete. When all lanes complete on the same edge, all_eios and all eios_det bits are high together.
- fts_count updates in the same cycle that fts_det[0] is high.
- A sym_valid=0 gap of any length inside an ordered set is transparent; detection timing is counted in valid symbols.
- Reset values: every pulse output, eios_seen, all FSM states and counters = 0 (states = IDLE); fts_count = 0.
- Reset asserted mid-sequence aborts it, and no pulse is generated for the partial ordered set after release.
- No pulse is ever longer than one cycle. A new COM in the terminating slot may start the next OS with zero bubbles.

## Test plan
- Lane 0 receives K COM, SKP, SKP, SKP, then D 0x4A at edge 5 -> skp_det=0001 during cycle 6 only; no os_err.
- Lane 1 receives K COM followed by six K SKP -> os_err[1] pulses the cycle after the sixth SKP; skp_det[1] never pulses.
- With LANES=4, EIOS (K COM, IDL, IDL, IDL) completes on lanes 0..3 at edges 10, 11, 12 and 13 -> eios_det pulses on bits 0..3 during cycles 11..14; all_eios is high only during cycle 14.
- Lane 0 receives 257 consecutive FTS OS -> fts_count reaches 255 and holds; fts_clr asserted on the same edge as fts_det[0] -> fts_count=0.
- EIOS on lane 2 with sym_valid=0 for 3 cycles between the 2nd and 3rd IDL -> eios_det[2] pulses the cycle after the 3rd valid IDL. Separately, rst_n pulsed low after K COM, SKP -> no skp_det after release.
- Lane 3 receives K COM, IDL, then D 0x00 -> os_err[3] pulses once; eios_det[3] does not pulse. Lane 3 receives K COM, K COM, FTS, FTS, FTS -> fts_det[3] pulses once, with no os_err.
